// File: rtl/sram_pkg.sv
// Shared types and widths for the external SRAM pin responder.
package sram_pkg;

    localparam int unsigned SRAM_DQ_W   = 16;
    localparam int unsigned SRAM_ADDR_W = 18;

    // Byte-lane enables, active-high: {ub, lb}.
    typedef logic [1:0] sram_lane_t;

    // Classification of one sampled pin cycle.
    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_WRITE = 2'd1,
        SR_READ  = 2'd2
    } sram_class_e;

    // One in-flight read: valid, lanes requested at sample time, array data.
    typedef struct packed {
        logic                 valid;
        sram_lane_t           lane;
        logic [SRAM_DQ_W-1:0] data;
    } sram_rd_ent_t;

endpackage

// File: rtl/sram_read_pipe.sv
// Read data pipeline: DEPTH-stage shift register of read entries.
// Ports: clk_i clock, rst_ni synchronous active-low clear,
//        ent_i entry entering stage 0, ent_o last (output) stage.
module sram_read_pipe
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  sram_rd_ent_t ent_i,
    output sram_rd_ent_t ent_o
);

    sram_rd_ent_t stage_q [DEPTH];

    // Shift every cycle; entries retire whether or not they were driven.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= ent_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign ent_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_responder.sv
// Clocked responder for a 16-bit async-style SRAM pin interface.
// Ports: clk / rst (sync, active-low); SRAM_* pin strobes, address and
// shared DQ bus; wr_count_out / rd_count_out saturating access counters;
// contention_out sticky WE+OE flag; dbg_addr_in / dbg_data_out backdoor read.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQInOut,
    input  logic [SRAM_ADDR_W-1:0] SRAM_ADDRIn,
    input  logic                   SRAM_UB_NIn,
    input  logic                   SRAM_LB_NIn,
    input  logic                   SRAM_WE_NIn,
    input  logic                   SRAM_CE_NIn,
    input  logic                   SRAM_OE_NIn,
    output logic [15:0]            wr_count_out,
    output logic [15:0]            rd_count_out,
    output logic                   contention_out,
    input  logic [SRAM_ADDR_W-1:0] dbg_addr_in,
    output logic [SRAM_DQ_W-1:0]   dbg_data_out
);

    localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

    logic [SRAM_DQ_W-1:0]  mem_q [DEPTH];

    sram_class_e           cls_c;
    sram_lane_t            lane_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic [DEPTH_LOG2-1:0] dbg_idx_c;
    logic [SRAM_DQ_W-1:0]  dq_in_c;
    logic [SRAM_DQ_W-1:0]  wr_word_c;

    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic                  cont_q, cont_d;
    logic [SRAM_DQ_W-1:0]  dbg_q, dbg_d;
    sram_rd_ent_t          samp_q, samp_d;
    sram_rd_ent_t          pipe_out;
    logic                  drv_hi_c, drv_lo_c;

    assign dq_in_c   = SRAM_DQInOut;
    assign lane_c    = {~SRAM_UB_NIn, ~SRAM_LB_NIn};
    assign idx_c     = SRAM_ADDRIn[DEPTH_LOG2-1:0];
    assign dbg_idx_c = dbg_addr_in[DEPTH_LOG2-1:0];

    // Address bits above the array size alias and are ignored.
    if (DEPTH_LOG2 < SRAM_ADDR_W) begin : g_alias
        logic unused_addr_c;
        assign unused_addr_c = ^{SRAM_ADDRIn[SRAM_ADDR_W-1:DEPTH_LOG2],
                                 dbg_addr_in[SRAM_ADDR_W-1:DEPTH_LOG2]};
    end

    // Cycle classification; WRITE wins over OE so contention still commits.
    always_comb begin
        cls_c = SR_IDLE;
        if (!SRAM_CE_NIn && !SRAM_WE_NIn) begin
            cls_c = SR_WRITE;
        end else if (!SRAM_CE_NIn && !SRAM_OE_NIn) begin
            cls_c = SR_READ;
        end
    end

    // Byte-masked merge of the bus data into the addressed word.
    always_comb begin
        wr_word_c = mem_q[idx_c];
        if (lane_c[1]) wr_word_c[15:8] = dq_in_c[15:8];
        if (lane_c[0]) wr_word_c[7:0]  = dq_in_c[7:0];
    end

    // Storage array: never cleared; reset blocks a coincident write.
    always_ff @(posedge clk) begin
        if (rst && (cls_c == SR_WRITE)) begin
            mem_q[idx_c] <= wr_word_c;
        end
    end

    // Next-state for counters, contention flag, backdoor and read sample.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        cont_d   = cont_q;
        dbg_d    = mem_q[dbg_idx_c];
        samp_d   = '0;
        if (cls_c == SR_WRITE) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            if (!SRAM_OE_NIn)         cont_d   = 1'b1;
        end
        if (cls_c == SR_READ) begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            samp_d.valid = 1'b1;
            samp_d.lane  = lane_c;
            samp_d.data  = mem_q[idx_c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            cont_q   <= 1'b0;
            dbg_q    <= '0;
            samp_q   <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            cont_q   <= cont_d;
            dbg_q    <= dbg_d;
            samp_q   <= samp_d;
        end
    end

    // The sample register plus READ_LAT stages puts data on DQ after edge t+L.
    sram_read_pipe #(
        .DEPTH (READ_LAT)
    ) u_pipe (
        .clk_i  (clk),
        .rst_ni (rst),
        .ent_i  (samp_q),
        .ent_o  (pipe_out)
    );

    // Drive only while the controller still holds a read cycle on the pins.
    assign drv_hi_c = pipe_out.valid && (cls_c == SR_READ) && pipe_out.lane[1];
    assign drv_lo_c = pipe_out.valid && (cls_c == SR_READ) && pipe_out.lane[0];

    assign SRAM_DQInOut[15:8] = drv_hi_c ? pipe_out.data[15:8] : 8'hzz;
    assign SRAM_DQInOut[7:0]  = drv_lo_c ? pipe_out.data[7:0]  : 8'hzz;

    assign wr_count_out   = wr_cnt_q;
    assign rd_count_out   = rd_cnt_q;
    assign contention_out = cont_q;
    assign dbg_data_out   = dbg_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (READ_LAT 1 and 3) share all
// strobes; DQ nets pull high so an undriven lane reads as 8'hFF.
module tb_sram_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce_n, we_n, oe_n, ub_n, lb_n;
    logic [17:0] addr, dbg_addr;
    logic        tb_drv;
    logic [15:0] tb_dq;

    tri1 [15:0]  dq1;
    tri1 [15:0]  dq3;
    assign dq1 = tb_drv ? tb_dq : 16'hzzzz;
    assign dq3 = tb_drv ? tb_dq : 16'hzzzz;

    logic [15:0] wr1, rd1, dbg1, wr3, rd3, dbg3;
    logic        cont1, cont3;

    sram_responder #(.DEPTH_LOG2(16), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .SRAM_DQInOut(dq1), .SRAM_ADDRIn(addr),
        .SRAM_UB_NIn(ub_n), .SRAM_LB_NIn(lb_n), .SRAM_WE_NIn(we_n),
        .SRAM_CE_NIn(ce_n), .SRAM_OE_NIn(oe_n),
        .wr_count_out(wr1), .rd_count_out(rd1), .contention_out(cont1),
        .dbg_addr_in(dbg_addr), .dbg_data_out(dbg1)
    );

    sram_responder #(.DEPTH_LOG2(16), .READ_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .SRAM_DQInOut(dq3), .SRAM_ADDRIn(addr),
        .SRAM_UB_NIn(ub_n), .SRAM_LB_NIn(lb_n), .SRAM_WE_NIn(we_n),
        .SRAM_CE_NIn(ce_n), .SRAM_OE_NIn(oe_n),
        .wr_count_out(wr3), .rd_count_out(rd3), .contention_out(cont3),
        .dbg_addr_in(dbg_addr), .dbg_data_out(dbg3)
    );

    // Reference model: word array, saturating counts, and a history of
    // read samples indexed by edge number.
    logic [15:0] mem_m [65536];
    int          n_edge;
    int          last_rst;
    int unsigned m_wr, m_rd;
    logic        m_cont;
    logic [15:0] m_dbg;
    int          hist_t    [8];
    logic        hist_v    [8];
    logic [1:0]  hist_lane [8];
    logic [15:0] hist_d    [8];
    logic        chk_en;

    logic [15:0] obs1, obs3, obs_wr, obs_rd, obs_dbg;
    logic        obs_cont;

    int unsigned n_chk, n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n_edge);
    endtask

    // DQ expected now for a device of latency lat: a read sampled lat+1 edges
    // ago, not wiped by a later reset, shown only while pins still say READ.
    function automatic logic [15:0] exp_dq(input int lat);
        logic [15:0] e;
        int          t;
        int          s;
        e = 16'hFFFF;
        t = n_edge - 1 - lat;
        if (!ce_n && we_n && !oe_n && t >= 0 && t > last_rst) begin
            s = t % 8;
            if (hist_t[s] == t && hist_v[s]) begin
                if (hist_lane[s][1]) e[15:8] = hist_d[s][15:8];
                if (hist_lane[s][0]) e[7:0]  = hist_d[s][7:0];
            end
        end
        return e;
    endfunction

    // Apply what the pins hold at the current edge to the model.
    task automatic model_edge();
        logic        is_w, is_r;
        logic [15:0] idx;
        int          s;
        is_w = !ce_n && !we_n;
        is_r = !ce_n && we_n && !oe_n;
        idx  = addr[15:0];
        s    = n_edge % 8;
        hist_t[s]    = n_edge;
        hist_v[s]    = rst && is_r;
        hist_lane[s] = {~ub_n, ~lb_n};
        hist_d[s]    = mem_m[idx];
        if (!rst) begin
            m_wr = 0; m_rd = 0; m_cont = 1'b0; m_dbg = 16'h0;
            last_rst = n_edge;
        end else begin
            m_dbg = mem_m[dbg_addr[15:0]];
            if (is_w) begin
                if (!ub_n) mem_m[idx][15:8] = tb_dq[15:8];
                if (!lb_n) mem_m[idx][7:0]  = tb_dq[7:0];
                if (m_wr < 65535) m_wr++;
                if (!oe_n) m_cont = 1'b1;
            end
            if (is_r && m_rd < 65535) m_rd++;
        end
    endtask

    // One clock: set pins mid-low phase, compare outputs, then take the edge.
    task automatic cyc(input logic r, input logic ce, input logic we, input logic oe,
                       input logic ub, input logic lb, input logic [17:0] a,
                       input logic [15:0] wd, input logic [17:0] da);
        @(negedge clk);
        rst = r; ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb;
        addr = a; tb_dq = wd; dbg_addr = da; tb_drv = !we;
        #1;
        obs1 = dq1; obs3 = dq3; obs_wr = wr1; obs_rd = rd1;
        obs_dbg = dbg1; obs_cont = cont1;
        if (chk_en) begin
            if (we) begin
                check("dq_lat1", 32'(dq1), 32'(exp_dq(1)));
                check("dq_lat3", 32'(dq3), 32'(exp_dq(3)));
            end
            check("wr_count1", 32'(wr1), m_wr);
            check("rd_count1", 32'(rd1), m_rd);
            check("contention1", 32'(cont1), 32'(m_cont));
            check("dbg_data1", 32'(dbg1), 32'(m_dbg));
            check("wr_count3", 32'(wr3), m_wr);
            check("rd_count3", 32'(rd3), m_rd);
            check("contention3", 32'(cont3), 32'(m_cont));
            check("dbg_data3", 32'(dbg3), 32'(m_dbg));
        end
        @(posedge clk);
        model_edge();
        n_edge++;
    endtask

    initial begin
        logic [15:0] old;
        int          op;
        logic        rv, c, w, o;

        rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1;
        addr = '0; dbg_addr = '0; tb_dq = '0; tb_drv = 1'b0;
        n_edge = 0; last_rst = -1; m_wr = 0; m_rd = 0; m_cont = 1'b0; m_dbg = '0;
        n_chk = 0; n_pass = 0; chk_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            hist_t[i] = -1; hist_v[i] = 1'b0; hist_lane[i] = '0; hist_d[i] = '0;
        end
        for (int i = 0; i < 65536; i++) mem_m[i] = '0;

        // Power-up reset; outputs are unknown before it, so no checks.
        cyc(1'b0, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h0);
        chk_en = 1'b1;

        // Fill every word (aliased upper address bits); counter must saturate.
        for (int i = 0; i < 65536; i++) begin
            cyc(1'b1, 0, 0, 1, 0, 0, {2'($urandom_range(0, 3)), 16'(i)},
                16'($urandom), 18'($urandom));
        end
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h0);
        check("wr_saturate", 32'(obs_wr), 32'hFFFF);

        // Write then read-back with latency 1.
        cyc(1'b0, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h0);
        cyc(1'b1, 0, 0, 1, 0, 0, 18'h00010, 16'hBEEF, 18'h0);
        cyc(1'b1, 0, 1, 0, 0, 0, 18'h00010, 16'h0, 18'h0);
        cyc(1'b1, 0, 1, 0, 0, 0, 18'h00010, 16'h0, 18'h0);
        check("beef_wr_count", 32'(obs_wr), 32'd1);
        check("beef_rd_count", 32'(obs_rd), 32'd1);
        cyc(1'b1, 0, 1, 0, 0, 0, 18'h00010, 16'h0, 18'h0);
        check("beef_dq", 32'(obs1), 32'hBEEF);

        // Lower-lane-only write over an existing word.
        cyc(1'b1, 0, 0, 1, 0, 0, 18'h00020, 16'h1234, 18'h0);
        cyc(1'b1, 0, 0, 1, 1, 0, 18'h00020, 16'hABCD, 18'h0);
        cyc(1'b1, 0, 1, 0, 0, 0, 18'h00020, 16'h0, 18'h0);
        cyc(1'b1, 0, 1, 0, 0, 0, 18'h00020, 16'h0, 18'h0);
        cyc(1'b1, 0, 1, 0, 0, 0, 18'h00020, 16'h0, 18'h0);
        check("lane_merge_dq", 32'(obs1), 32'h12CD);

        // Upper-lane-only read, then OE released before the data phase.
        cyc(1'b1, 0, 1, 0, 0, 1, 18'h00020, 16'h0, 18'h0);
        cyc(1'b1, 0, 1, 0, 0, 1, 18'h00020, 16'h0, 18'h0);
        cyc(1'b1, 0, 1, 0, 0, 1, 18'h00020, 16'h0, 18'h0);
        check("ub_only_dq", 32'(obs1), 32'h12FF);
        cyc(1'b1, 0, 1, 1, 0, 1, 18'h00020, 16'h0, 18'h0);
        check("oe_dropped_dq", 32'(obs1), 32'hFFFF);

        // Latency-3 pipelined burst.
        for (int k = 0; k < 4; k++) cyc(1'b1, 0, 0, 1, 0, 0, 18'(k), 16'(k + 1), 18'h0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 0, 1, 0, 0, 0, (k < 4) ? 18'(k) : 18'h0, 16'h0, 18'h0);
            if (k >= 4) check("lat3_burst", 32'(obs3), 32'(k - 3));
        end

        // Contention write, then reset: state clears but the array keeps data.
        cyc(1'b1, 0, 0, 0, 0, 0, 18'h00040, 16'h5555, 18'h00040);
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00040);
        check("contention_set", 32'(obs_cont), 32'd1);
        cyc(1'b0, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00040);
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00040);
        check("rst_contention", 32'(obs_cont), 32'd0);
        check("rst_wr_count", 32'(obs_wr), 32'd0);
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00040);
        check("contention_data", 32'(obs_dbg), 32'h5555);

        // Address aliasing via the backdoor.
        cyc(1'b1, 0, 0, 1, 0, 0, 18'h10005, 16'hC0DE, 18'h0);
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00005);
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00005);
        check("alias_dbg", 32'(obs_dbg), 32'hC0DE);

        // Reset coincident with a write blocks the write.
        old = mem_m[16'h0077];
        cyc(1'b0, 0, 0, 1, 0, 0, 18'h00077, 16'hDEAD, 18'h00077);
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00077);
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h00077);
        check("rst_blocks_write", 32'(obs_dbg), 32'(old));

        // Randomized traffic with sticky operation class and rare resets.
        op = 2;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) op = $urandom_range(0, 4);
            rv = ($urandom_range(0, 63) != 0);
            case (op)
                0:       begin c = 1'b1; w = 1'($urandom); o = 1'($urandom); end
                1:       begin c = 1'b0; w = 1'b0; o = 1'b1; end
                2:       begin c = 1'b0; w = 1'b1; o = 1'b0; end
                3:       begin c = 1'b0; w = 1'b0; o = 1'b0; end
                default: begin c = 1'b0; w = 1'b1; o = 1'b1; end
            endcase
            cyc(rv, c, w, o, 1'($urandom), 1'($urandom), 18'($urandom),
                16'($urandom), 18'($urandom));
        end
        cyc(1'b1, 1, 1, 1, 1, 1, 18'h0, 16'h0, 18'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Clocked responder model for the 16-bit external SRAM pin interface driven by the processor's SRAM controller in the MEM stage. It decodes the active-low chip, write, output and byte-lane strobes, commits byte-masked writes into an internal word array, and returns read data on the shared DQ bus after a parameterised number of cycles. It also keeps access counters and flags illegal strobe combinations, so CPU-level benches can check memory traffic without probing the controller.

## Interface
- DEPTH_LOG2, 16, words of storage = 2^DEPTH_LOG2; address bits above this are ignored, so addresses alias.
- READ_LAT, 1, cycles from read sample to DQ drive; legal range 1..4.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- SRAM_DQInOut  inout  16  data bus; driven only during a read data phase, Z otherwise.
- SRAM_ADDRIn  in  18  word address.
- SRAM_UB_NIn  in  1  upper byte lane enable, active-low, DQ[15:8].
- SRAM_LB_NIn  in  1  lower byte lane enable, active-low, DQ[7:0].
- SRAM_WE_NIn  in  1  write enable, active-low.
- SRAM_CE_NIn  in  1  chip enable, active-low.
- SRAM_OE_NIn  in  1  output enable, active-low.
- wr_count_out  out  16  committed write cycles, saturating.
- rd_count_out  out  16  sampled read cycles, saturating.
- contention_out  out  1  sticky flag: WE_N and OE_N were both low while CE_N was low.
- dbg_addr_in  in  18  backdoor read address.
- dbg_data_out  out  16  mem[dbg_addr_in], registered, 1-cycle latency.

## Operation
- Each rising edge, the block samples the strobes and classifies the cycle:
  - **WRITE**: CE_N=0, WE_N=0.
  - **READ**: CE_N=0, WE_N=1, OE_N=0.
  - **IDLE**: any other combination.
- **WRITE** behaviour:
  - mem[addr] upper byte takes DQ[15:8] when UB_N=0; lower byte takes DQ[7:0] when LB_N=0.
  - A lane that is disabled keeps its old byte. With both lanes disabled the write is a no-op, but it is still counted.
  - If OE_N=0 in the same cycle, contention_out is set, the write still commits, and no read is sampled.
- **READ** behaviour:
  - Pushes {valid, lane mask, mem[addr]} into the read pipeline. Data is taken from the array state before this edge.
  - A write at edge t followed by a read sampled at edge t+1 returns the new data.
- **Drive** rule: the pipeline output stage drives DQ only when all of the following hold:
  - the output stage is valid;
  - the current strobes are still CE_N=0, WE_N=1, OE_N=0.
- Lane masking during drive: each lane is driven only if its byte enable was low when the read was sampled. Undriven lanes are Z.
- If the strobes change before the data phase, that entry drives nothing. The entry still retires; it is not held.
- Counters increment by 1 per WRITE or READ cycle and saturate at 16'hFFFF.
- contention_out clears only on reset.
- Array contents are not cleared by reset.
- Reset (rst=0 at an edge) values:
  - pipeline valid bits, counters, contention_out, dbg_data_out: all 0.
  - DQ: Z, from the first cycle after the reset edge onward.
  - Reset asserted mid-read drops the in-flight entries, so nothing is driven.
  - Reset asserted during a WRITE edge blocks that write; reset has priority.

## Timing
- Read with READ_LAT=L: address and strobes are sampled at edge t. DQ is valid from just after edge t+L until edge t+L+1.
- Back-to-back reads on consecutive edges give one data word per cycle, fully pipelined.
- Write-to-read turnaround: 0 idle cycles needed.
- Read-to-write turnaround: the controller must deassert OE_N before the WRITE edge. The responder never drives DQ during a WRITE-classified cycle.
- dbg_data_out: updated 1 cycle after dbg_addr_in. The backdoor port is independent of the pin traffic.

## Structure
- Shared package sram_pkg holds:
  - SRAM_DQ_W = 16 and SRAM_ADDR_W = 18;
  - the typedef sram_lane_t (2-bit, {ub, lb}, active-high);
  - the cycle-class enum {SR_IDLE, SR_WRITE, SR_READ}.
- Sub-module sram_read_pipe: a READ_LAT-deep shift register of {valid, lane, data} with synchronous clear. The top level holds the array, the decode, the counters and the tristate.

## Test plan
- Write 16'hBEEF at address 18'h00010 with both lanes enabled, then read at the next edge with READ_LAT=1 -> DQ = 16'hBEEF one cycle after the read sample; wr_count_out = 1, rd_count_out = 1.
- Write 16'h1234 at 18'h00020, then write 16'hABCD at the same address with UB_N=1, then read -> DQ = 16'h12CD.
- Read at 18'h00020 with UB_N=0, LB_N=1 -> DQ[15:8] = 8'h12, DQ[7:0] = Z. Raise OE_N before the data phase -> DQ fully Z.
- READ_LAT=3: four reads on consecutive edges of 18'h0..18'h3 preloaded with 1..4 -> DQ shows 1, 2, 3, 4 on cycles t+3..t+6.
- Drive CE_N=0, WE_N=0, OE_N=0 with DQ=16'h5555 -> write commits, contention_out = 1, DQ not driven. Then apply rst=0 for one edge -> counters = 0, contention_out = 0, and the backdoor read at that address still returns 16'h5555.
- With DEPTH_LOG2=16: write at 18'h10005, then backdoor read 18'h00005 -> dbg_data_out equals the written word. Issue 65,536 writes -> wr_count_out holds at 16'hFFFF.
